// File: rtl/tx_ctrl_fsm_n.sv
// Transmit-layer control FSM supervising NUM_FIFOS FIFOs: threshold latch, idle/active
// tracking with all-empty timeout, and maskable sticky error capture with recovery.
module tx_ctrl_fsm_n #(
  parameter int unsigned NUM_FIFOS    = 5,
  parameter int unsigned NUM_UMB      = 3,
  parameter int unsigned UMB_W        = 4,
  parameter int unsigned IDLE_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic                     clear_err,
  input  logic [NUM_UMB*UMB_W-1:0] umbral_in,
  input  logic [NUM_FIFOS-1:0]     fifo_empty,
  input  logic [NUM_FIFOS-1:0]     fifo_error,
  input  logic [NUM_FIFOS-1:0]     error_mask,
  output logic [2:0]               state,
  output logic                     idle_out,
  output logic                     active_out,
  output logic                     error_out,
  output logic [NUM_FIFOS-1:0]     err_src,
  output logic [NUM_UMB*UMB_W-1:0] umbral_out
);

  localparam int unsigned CntW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(IDLE_TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(IDLE_TIMEOUT);

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StInit   = 3'd1,
    StIdle   = 3'd2,
    StActive = 3'd3,
    StError  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q;
  logic [NUM_FIFOS-1:0]  err_vec;
  logic                  err_any, all_empty, timeout_hit;

  assign err_vec     = fifo_error & ~error_mask;
  assign err_any     = |err_vec;
  assign all_empty   = &fifo_empty;
  assign timeout_hit = (IDLE_TIMEOUT != 0) && all_empty && (cnt_q == CntLast);
  assign state       = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  state_d = StInit;
      StInit:   if (init) state_d = StIdle;
      StIdle: begin
        if (err_any)         state_d = StError;
        else if (!all_empty) state_d = StActive;
      end
      StActive: begin
        if (err_any)          state_d = StError;
        else if (timeout_hit) state_d = StIdle;
      end
      StError:  if (clear_err) state_d = StInit;
      default:  state_d = StReset;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StReset;
      idle_out   <= 1'b0;
      active_out <= 1'b0;
      error_out  <= 1'b0;
      err_src    <= '0;
      umbral_out <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idle_out   <= (state_d == StIdle);
      active_out <= (state_d == StActive);
      error_out  <= (state_d == StError);
      cnt_q      <= '0;
      case (state_q)
        StInit: umbral_out <= umbral_in;
        StIdle: if (err_any) err_src <= err_vec;
        StActive: begin
          if (err_any) begin
            err_src <= err_vec;
          end else if (all_empty && !timeout_hit) begin
            cnt_q <= (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
          end
        end
        StError: begin
          // Recovery beats a same-edge error; that error is dropped.
          if (clear_err) err_src <= '0;
          else           err_src <= err_src | err_vec;
        end
        StReset: ;
        default: begin
          err_src    <= '0;
          umbral_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_ctrl_fsm_n.sv
// Scoreboard bench for tx_ctrl_fsm_n: driver queues hand-computed expectations per edge,
// a negedge monitor pops and compares them.
module tb_tx_ctrl_fsm_n;

  localparam int unsigned NF = 5;
  localparam int unsigned UW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0, clear_err = 1'b0;
  logic [UW-1:0] umbral_in = '0;
  logic [NF-1:0] fifo_empty = '1, fifo_error = '0, error_mask = '0;
  logic [2:0]    state;
  logic          idle_out, active_out, error_out;
  logic [NF-1:0] err_src;
  logic [UW-1:0] umbral_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]    st;
    logic [NF-1:0] es;
    logic [UW-1:0] um;
  } exp_t;

  exp_t sb_q[$];

  tx_ctrl_fsm_n #(
    .NUM_FIFOS   (5),
    .NUM_UMB     (3),
    .UMB_W       (4),
    .IDLE_TIMEOUT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .clear_err (clear_err),
    .umbral_in (umbral_in),
    .fifo_empty(fifo_empty),
    .fifo_error(fifo_error),
    .error_mask(error_mask),
    .state     (state),
    .idle_out  (idle_out),
    .active_out(active_out),
    .error_out (error_out),
    .err_src   (err_src),
    .umbral_out(umbral_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic compare(input exp_t e);
    check("state", 32'(state), 32'(e.st));
    check("flags", {29'd0, idle_out, active_out, error_out},
          {29'd0, e.st == 3'd2, e.st == 3'd3, e.st == 3'd4});
    check("err_src", 32'(err_src), 32'(e.es));
    check("umbral_out", 32'(umbral_out), 32'(e.um));
  endtask

  // Monitor: each queued entry describes the outputs after the preceding posedge.
  always @(negedge clk) begin
    if (sb_q.size() != 0) compare(sb_q.pop_front());
  end

  task automatic step(input logic in_init, input logic in_clr, input logic [UW-1:0] in_um,
                      input logic [NF-1:0] in_emp, input logic [NF-1:0] in_err,
                      input logic [NF-1:0] in_msk,
                      input logic [2:0] e_st, input logic [NF-1:0] e_es,
                      input logic [UW-1:0] e_um);
    @(negedge clk);
    #1;
    init       = in_init;
    clear_err  = in_clr;
    umbral_in  = in_um;
    fifo_empty = in_emp;
    fifo_error = in_err;
    error_mask = in_msk;
    sb_q.push_back('{st: e_st, es: e_es, um: e_um});
  endtask

  initial begin
    #2;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outs", {idle_out, active_out, error_out, err_src, umbral_out}, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    umbral_in = 12'h3A5;
    sb_q.push_back('{st: 3'd1, es: 5'b0, um: 12'h000});
    //   init clr umbral   empty     error     mask      st    err_src   umbral_out
    step(0, 0, 12'h3A5, 5'b11111, 5'b00000, 5'b00000, 3'd1, 5'b00000, 12'h3A5);
    step(1, 0, 12'h7C2, 5'b11111, 5'b00000, 5'b00000, 3'd2, 5'b00000, 12'h7C2);
    step(0, 0, 12'h111, 5'b11111, 5'b00000, 5'b00000, 3'd2, 5'b00000, 12'h7C2);
    step(0, 0, 12'h111, 5'b11011, 5'b00000, 5'b00000, 3'd3, 5'b00000, 12'h7C2);
    for (int i = 0; i < 3; i++)
      step(0, 0, 12'h111, 5'b11111, 5'b00000, 5'b00000, 3'd3, 5'b00000, 12'h7C2);
    step(0, 0, 12'h111, 5'b11110, 5'b00000, 5'b00000, 3'd3, 5'b00000, 12'h7C2);
    for (int i = 0; i < 3; i++)
      step(0, 0, 12'h111, 5'b11111, 5'b00000, 5'b00000, 3'd3, 5'b00000, 12'h7C2);
    step(0, 0, 12'h111, 5'b11111, 5'b00000, 5'b00000, 3'd2, 5'b00000, 12'h7C2);
    step(0, 0, 12'h111, 5'b11011, 5'b00000, 5'b00000, 3'd3, 5'b00000, 12'h7C2);
    step(0, 0, 12'h111, 5'b11011, 5'b00100, 5'b00100, 3'd3, 5'b00000, 12'h7C2);
    step(0, 0, 12'h111, 5'b11011, 5'b00001, 5'b00100, 3'd4, 5'b00001, 12'h7C2);
    step(0, 0, 12'h111, 5'b11011, 5'b10000, 5'b00100, 3'd4, 5'b10001, 12'h7C2);
    step(1, 0, 12'h111, 5'b11011, 5'b00100, 5'b00100, 3'd4, 5'b10001, 12'h7C2);
    step(0, 1, 12'h111, 5'b11011, 5'b01000, 5'b00000, 3'd1, 5'b00000, 12'h7C2);
    step(1, 0, 12'h0F0, 5'b11111, 5'b00000, 5'b00000, 3'd2, 5'b00000, 12'h0F0);
    step(0, 1, 12'h0F0, 5'b11111, 5'b00000, 5'b00000, 3'd2, 5'b00000, 12'h0F0);
    step(0, 0, 12'h0F0, 5'b01111, 5'b00010, 5'b00000, 3'd4, 5'b00010, 12'h0F0);
    step(0, 1, 12'h0F0, 5'b01111, 5'b00000, 5'b00000, 3'd1, 5'b00000, 12'h0F0);
    step(1, 0, 12'h0F0, 5'b11111, 5'b00000, 5'b00000, 3'd2, 5'b00000, 12'h0F0);
    step(0, 0, 12'h0F0, 5'b00000, 5'b00000, 5'b00000, 3'd3, 5'b00000, 12'h0F0);
    for (int i = 0; i < 6; i++)
      step(0, 0, 12'h0F0, 5'b00000, 5'b00000, 5'b00000, 3'd3, 5'b00000, 12'h0F0);

    // Bounded drain of the scoreboard before the asynchronous reset check.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();

    #3 reset = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_outs", {idle_out, active_out, error_out, err_src, umbral_out}, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    sb_q.push_back('{st: 3'd1, es: 5'b0, um: 12'h000});
    step(0, 0, 12'h5A5, 5'b11111, 5'b00000, 5'b00000, 3'd1, 5'b00000, 12'h5A5);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drained_end", 32'(sb_q.size()), 32'd0);

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_ctrl_fsm_n.md
Name: tx_ctrl_fsm_n

Overview:
Parametrised control state machine for the PCIe transmit layer. It supervises an arbitrary number of FIFOs (main, VCs, Ds and future additions) and latches NUM_UMB per-class thresholds during initialisation. It reports IDLE/ACTIVE/ERROR status and which FIFOs caused the error. Compared with the fixed 5-FIFO controller, it adds a per-FIFO error mask, sticky error source capture, error recovery without a full reset, and an ACTIVE->IDLE return after a programmable all-empty timeout.

Parameters:
NUM_FIFOS, 5, number of supervised FIFOs; bit i of each FIFO vector refers to the same FIFO.
NUM_UMB, 3, number of threshold fields.
UMB_W, 4, width of each threshold field.
IDLE_TIMEOUT, 8, consecutive all-empty cycles in ACTIVE before returning to IDLE; 0 disables the return.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; forces the RESET state and clears all registers
init  in  1  ends initialisation; in INIT, 1 moves to IDLE
clear_err  in  1  ERROR recovery request
umbral_in  in  NUM_UMB*UMB_W  packed thresholds; field k is bits [k*UMB_W +: UMB_W]
fifo_empty  in  NUM_FIFOS  per-FIFO empty flags
fifo_error  in  NUM_FIFOS  per-FIFO error flags
error_mask  in  NUM_FIFOS  1 = ignore fifo_error[i]
state  out  3  encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4
idle_out  out  1  1 while in IDLE
active_out  out  1  1 while in ACTIVE
error_out  out  1  1 while in ERROR
err_src  out  NUM_FIFOS  sticky OR of unmasked errors since ERROR entry
umbral_out  out  NUM_UMB*UMB_W  latched thresholds

Behaviour:
- All outputs are registered. A condition sampled at edge n is visible after edge n.
- Reset (asynchronous, immediate on assertion): state=RESET; idle_out, active_out, error_out=0; err_src=0; umbral_out=0; timeout counter=0.
- err_any = |(fifo_error & ~error_mask). all_empty = &fifo_empty.
- State outputs: idle_out, active_out and error_out are one-hot functions of the registered state. In RESET and INIT all three are 0.
- RESET: moves to INIT on the first clock edge with reset low.
- INIT:
  - umbral_out <= umbral_in on every edge, including the edge where init=1.
  - init=1 -> IDLE.
  - umbral_out is frozen in every state other than INIT.
- IDLE:
  - err_any -> ERROR. Error has priority over non-empty.
  - else !all_empty -> ACTIVE.
  - else stay in IDLE.
- ACTIVE:
  - err_any -> ERROR (highest priority).
  - Timeout counter, width clog2(IDLE_TIMEOUT+1), saturating:
    - increments on each edge with all_empty;
    - clears on any non-empty cycle and on entry to ACTIVE.
  - When all_empty and counter == IDLE_TIMEOUT-1 -> IDLE, and the counter clears. The transition happens on the IDLE_TIMEOUT-th consecutive all-empty edge.
  - IDLE_TIMEOUT=0: ACTIVE is left only for ERROR or reset.
- ERROR:
  - On the entry edge, err_src <= the unmasked error vector.
  - While in ERROR, err_src |= (fifo_error & ~error_mask) on each edge.
  - clear_err=1 -> INIT and err_src <= 0. clear_err wins over a simultaneous new error, and the new error is not recorded.
  - init is ignored in ERROR.
  - umbral_out keeps its value until the next INIT, which reloads it.
- Mask changes take effect on the same edge they are sampled. A masked bit never sets err_src.
- clear_err outside ERROR is ignored.
- Illegal state encodings (5..7) -> RESET on the next edge with all outputs cleared.

Test Plan:
- Reset mid-ACTIVE: reset pulse between edges -> state=0, all outputs 0 immediately, without waiting for clk. First edge after release gives state=1.
- Threshold latch: in INIT drive umbral_in=0x3A5, then init=1 with umbral_in=0x7C2 -> state=2 and umbral_out=0x7C2. Later changes of umbral_in leave umbral_out unchanged.
- Activity and timeout (IDLE_TIMEOUT=4): in IDLE drive fifo_empty=5'b11011 -> ACTIVE next edge. Then all 1s for 4 cycles -> idle_out=1 after the 4th edge. A non-empty cycle at count 3 restarts the count.
- Masked error: error_mask=5'b00100 with fifo_error=5'b00100 in ACTIVE -> stays ACTIVE, err_src=0.
- Sticky source: fifo_error=5'b00001 -> ERROR with err_src=5'b00001. Next cycle fifo_error=5'b10000 -> err_src=5'b10001. Then clear_err=1 together with fifo_error=5'b01000 -> state=1, err_src=0.
- Priority in IDLE: fifo_empty=5'b01111 and fifo_error=5'b00010 on the same edge -> ERROR, not ACTIVE, with err_src=5'b00010.
